// File: rtl/fram_sp_req_ctrl_pkg.sv
// Shared types and helpers for the fram_sp request controller.
package fram_sp_req_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Bits needed to hold a count of 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fram_sp_req_ctrl_rsp_fifo.sv
// Synchronous response FIFO; head is read straight from the storage flops.
module fram_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop)  rd_ptr <= inc(rd_ptr);
            if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fram_sp_req_ctrl.sv
// Initiator-side controller for the fram_sp single-port RAM: optional zero-fill,
// credit-based read issue and in-order read responses with backpressure.
module fram_sp_req_ctrl
    import fram_sp_req_ctrl_pkg::*;
#(
    parameter int MEM_SIZE  = 1024,
    parameter int AW        = 10,
    parameter int FPGA_DW   = 8,
    parameter int RSP_DEPTH = 4,
    parameter int INIT_EN   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [AW-1:0]      req_addr,
    input  logic [FPGA_DW-1:0] req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [FPGA_DW-1:0] rsp_data,
    output logic [AW-1:0]      ram_addr,
    output logic [FPGA_DW-1:0] ram_wr_data,
    output logic               ram_wr_en,
    output logic               ram_en,
    input  logic [FPGA_DW-1:0] ram_rd_data,
    output logic               init_done
);
    localparam int CW = cnt_w(RSP_DEPTH);

    state_t        state;
    logic [AW-1:0] init_cnt;
    logic          rd_inflight;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          credit_ok;
    logic          req_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            init_cnt    <= '0;
            init_done   <= (INIT_EN == 0);
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= req_acc & ~req_we;
            if (state == ST_INIT) begin
                if (init_cnt == AW'(MEM_SIZE - 1)) begin
                    state     <= ST_RUN;
                    init_done <= 1'b1;
                end else begin
                    init_cnt <= init_cnt + 1'b1;
                end
            end
        end
    end

    // A FIFO slot is reserved at issue, so only registered terms gate reads.
    always_comb begin
        credit_ok   = (int'(fifo_cnt) + int'(rd_inflight)) < RSP_DEPTH;
        req_ready   = ~rst & (state == ST_RUN) & (req_we | credit_ok);
        req_acc     = req_valid & req_ready;
        ram_en      = 1'b0;
        ram_wr_en   = 1'b0;
        ram_addr    = '0;
        ram_wr_data = '0;
        if (!rst) begin
            if (state == ST_INIT) begin
                ram_en    = 1'b1;
                ram_wr_en = 1'b1;
                ram_addr  = init_cnt;
            end else begin
                ram_en      = req_acc;
                ram_wr_en   = req_acc & req_we;
                ram_addr    = req_addr;
                ram_wr_data = req_wdata;
            end
        end
    end

    fram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .DW    (FPGA_DW),
        .CW    (CW)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_inflight),
        .push_data (ram_rd_data),
        .pop       (rsp_ready),
        .head      (rsp_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign rsp_valid = ~fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst && rd_inflight) assert (!fifo_full);
    end

endmodule
